// File: rtl/instr_timing_sequencer.sv
// Phase sequencer for the instruction-decode controller: fetch, execute and
// optional memory-operand phases with wait states, run/step control and bus timeout.
module instr_timing_sequencer #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       ir_opcode,
  input  logic             run,
  input  logic             step,
  input  logic             mem_rdy,
  input  logic             err_clr,
  output logic [2:0]       timer,
  output logic             commit,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int WW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(WAIT_MAX);

  // State encoding is the phase code itself, so timer doubles as the FSM debug view.
  typedef enum logic [2:0] {
    IDLE = 3'b100,
    F0   = 3'b000,
    F1   = 3'b001,
    EX   = 3'b011,
    M0   = 3'b101,
    M1   = 3'b111
  } state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic          mem_operand;
  logic          unused_opcode_bits;

  assign mem_operand        = (ir_opcode[7:2] == 6'b100000);
  assign unused_opcode_bits = ^ir_opcode[1:0];

  assign timer  = state;
  assign halted = (state == IDLE);

  always_comb begin
    commit = 1'b0;
    case (state)
      F0, EX, M0: commit = 1'b1;
      F1, M1:     commit = mem_rdy;
      default:    commit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      bus_err   <= 1'b0;
      instr_cnt <= '0;
    end else begin
      // A timeout set later in this block overrides a simultaneous clear.
      if (err_clr) bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus_err && (run || step)) state <= F0;
        end
        F0: begin
          state    <= F1;
          wait_cnt <= '0;
        end
        F1: begin
          if (mem_rdy) begin
            state    <= EX;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LIMIT) begin
            bus_err  <= 1'b1;
            state    <= IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        EX: begin
          if (mem_operand) begin
            state <= M0;
          end else begin
            instr_cnt <= instr_cnt + CNT_W'(1);
            state     <= (run && !bus_err) ? F0 : IDLE;
          end
        end
        M0: begin
          state    <= M1;
          wait_cnt <= '0;
        end
        M1: begin
          if (mem_rdy) begin
            wait_cnt  <= '0;
            instr_cnt <= instr_cnt + CNT_W'(1);
            state     <= (run && !bus_err) ? F0 : IDLE;
          end else if (wait_cnt == WAIT_LIMIT) begin
            bus_err  <= 1'b1;
            state    <= IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
